// File: rtl/matvec_mac_array_if.sv
// FIFO read-side and control/result bundle between the matrix/vector FIFO fill
// stage and the lockstep multiply-accumulate array.
interface matvec_mac_array_if #(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
);
    logic                         start;
    logic [N-1:0][DATA_W-1:0]     fifo_a_rd_data;
    logic [N-1:0]                 fifo_a_empty;
    logic [N-1:0]                 fifo_a_rd_en;
    logic [DATA_W-1:0]            fifo_b_rd_data;
    logic                         fifo_b_empty;
    logic                         fifo_b_rd_en;
    logic [N-1:0][ACC_W-1:0]      result;
    logic                         busy;
    logic                         done;

    modport master (
        output start,
        output fifo_a_rd_data,
        output fifo_a_empty,
        output fifo_b_rd_data,
        output fifo_b_empty,
        input  fifo_a_rd_en,
        input  fifo_b_rd_en,
        input  result,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  fifo_a_rd_data,
        input  fifo_a_empty,
        input  fifo_b_rd_data,
        input  fifo_b_empty,
        output fifo_a_rd_en,
        output fifo_b_rd_en,
        output result,
        output busy,
        output done
    );
endinterface

// File: rtl/matvec_mac_array.sv
// Lockstep matrix-vector multiply: pops N A-row FIFOs and the shared B FIFO
// together and accumulates C[i] = sum_j A[i][j]*B[j] on N parallel lanes.
module matvec_mac_array #(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    matvec_mac_array_if.slave bus
);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [N-1:0][ACC_W-1:0] result_q, result_d;
    logic                    issue;

    // A pop happens only when every FIFO can supply its element this cycle.
    always_comb begin
        issue = (state_q == S_RUN) && (issue_cnt_q < CNT_FULL) &&
                !(|bus.fifo_a_empty) && !bus.fifo_b_empty;
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        result_d    = result_q;
        rd_valid_d  = issue;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_RUN;
                    issue_cnt_d = '0;
                    acc_cnt_d   = '0;
                    result_d    = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                // Read data lands one cycle after the pop, so accumulate on rd_valid_q.
                if (rd_valid_q) begin
                    for (int i = 0; i < N; i++) begin
                        result_d[i] = result_q[i] +
                                      ACC_W'(bus.fifo_a_rd_data[i]) * ACC_W'(bus.fifo_b_rd_data);
                    end
                    acc_cnt_d = acc_cnt_q + 1'b1;
                    if (acc_cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            acc_cnt_q   <= '0;
            rd_valid_q  <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            rd_valid_q  <= rd_valid_d;
            result_q    <= result_d;
        end
    end

    assign bus.fifo_a_rd_en = {N{issue}};
    assign bus.fifo_b_rd_en = issue;
    assign bus.result       = result_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
endmodule

// File: tb/tb_matvec_mac_array.sv
// Scoreboard bench for matvec_mac_array: behavioural FIFOs feed the array,
// expected results and done cycles are queued at start and checked on done.
module tb_matvec_mac_array;
    typedef logic [23:0] res_t [8];
    typedef struct {
        res_t res;
        int   done_cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] a_mem [8][256];
    logic [7:0] b_mem [256];
    int         a_wr [8];
    int         a_rd [8];
    int         b_wr = 0;
    int         b_rd = 0;
    int         pop_base = 0;
    sb_t        sb[$];

    res_t exp_id, exp_max, exp_row, exp_diag, exp_anti, exp_lin;

    matvec_mac_array_if #(.N(8), .DATA_W(8), .ACC_W(24)) bus ();

    matvec_mac_array #(.N(8), .DATA_W(8), .ACC_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO read ports: data appears the edge after the pop strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (bus.fifo_a_rd_en[i] === 1'b1) begin
                bus.fifo_a_rd_data[i] <= a_mem[i][a_rd[i] & 255];
                a_rd[i] <= a_rd[i] + 1;
            end
        end
        if (bus.fifo_b_rd_en === 1'b1) begin
            bus.fifo_b_rd_data <= b_mem[b_rd & 255];
            b_rd <= b_rd + 1;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_empty
        assign bus.fifo_a_empty[g] = (a_wr[g] == a_rd[g]);
    end
    assign bus.fifo_b_empty = (b_wr == b_rd);

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] aElem(input int sc, input int i, input int j);
        case (sc)
            2:       return 8'd255;
            3:       return 8'(i + 1);
            4:       return (i == j) ? 8'd3 : 8'd1;
            7:       return (j == 7 - i) ? 8'd1 : 8'd0;
            8:       return 8'(i);
            default: return (i == j) ? 8'd1 : 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] bElem(input int sc, input int j);
        case (sc)
            2:       return 8'd255;
            8:       return 8'd1;
            default: return 8'(j + 1);
        endcase
    endfunction

    task automatic pushA(input int i, input logic [7:0] v);
        a_mem[i][a_wr[i] & 255] = v;
        a_wr[i] = a_wr[i] + 1;
    endtask

    task automatic pushB(input logic [7:0] v);
        b_mem[b_wr & 255] = v;
        b_wr = b_wr + 1;
    endtask

    task automatic loadFifos(input int sc, input bit skip_b, input int row5_cnt);
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8; i++) begin
                if (!(i == 5 && j >= row5_cnt)) pushA(i, aElem(sc, i, j));
            end
            if (!skip_b) pushB(bElem(sc, j));
        end
    endtask

    task automatic flushFifos();
        for (int i = 0; i < 8; i++) a_wr[i] = a_rd[i];
        b_wr = b_rd;
    endtask

    // Called at a falling edge; returns one cycle later with start dropped.
    task automatic applyStimulus(input res_t expv, input int stalls, input bit track);
        sb_t e;
        pop_base = b_rd;
        if (track) begin
            e.res      = expv;
            e.done_cyc = cyc + 10 + stalls;
            sb.push_back(e);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input res_t expv, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: done not seen within %0d cycles", tag, n);
            sb.delete();
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("%s_hold_lane%0d", tag, i), bus.result[i], expv[i]);
        checkOutput({tag, "_busy_idle"}, bus.busy, 0);
        checkOutput({tag, "_pop_count"}, b_rd - pop_base, 8);
    endtask

    // Monitor: pops the scoreboard on done and polices lockstep popping.
    initial begin
        sb_t e;
        bit  done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (done_prev) checkOutput("done_width", bus.done, 0);
                done_prev = bus.done;
                if (bus.busy) begin
                    checks++;
                    if (bus.fifo_a_rd_en !== {8{bus.fifo_b_rd_en}} ||
                        (bus.fifo_b_rd_en && (|bus.fifo_a_empty || bus.fifo_b_empty))) begin
                        errors++;
                        $display("[TB] FAIL rd_en_lockstep: a_rd_en=%b b_rd_en=%b a_empty=%b b_empty=%b",
                                 bus.fifo_a_rd_en, bus.fifo_b_rd_en, bus.fifo_a_empty, bus.fifo_b_empty);
                    end
                end
                if (bus.done === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_done: got done=1 required no done at cycle %0d", cyc);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("done_cycle", cyc, e.done_cyc);
                        for (int i = 0; i < 8; i++)
                            checkOutput($sformatf("result_lane%0d", i), bus.result[i], e.res[i]);
                    end
                end
            end
        end
    end

    initial begin
        exp_id   = '{24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8};
        exp_max  = '{24'd520200, 24'd520200, 24'd520200, 24'd520200,
                     24'd520200, 24'd520200, 24'd520200, 24'd520200};
        exp_row  = '{24'd36, 24'd72, 24'd108, 24'd144, 24'd180, 24'd216, 24'd252, 24'd288};
        exp_diag = '{24'd38, 24'd40, 24'd42, 24'd44, 24'd46, 24'd48, 24'd50, 24'd52};
        exp_anti = '{24'd8, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1};
        exp_lin  = '{24'd0, 24'd8, 24'd16, 24'd24, 24'd32, 24'd40, 24'd48, 24'd56};

        for (int i = 0; i < 8; i++) a_wr[i] = 0;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_rd_en", {bus.fifo_a_rd_en, bus.fifo_b_rd_en}, 0);
        checkOutput("reset_result", (bus.result != '0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Identity matrix with a surplus ninth entry that must stay unpopped.
        loadFifos(1, 1'b0, 8);
        for (int i = 0; i < 8; i++) pushA(i, 8'd99);
        pushB(8'd99);
        applyStimulus(exp_id, 0, 1'b1);
        waitDone(exp_id, "s1");
        checkOutput("s1_surplus_kept", b_wr - b_rd, 1);
        flushFifos();

        loadFifos(2, 1'b0, 8);
        applyStimulus(exp_max, 0, 1'b1);
        waitDone(exp_max, "s2");

        // B FIFO empty for the first three RUN cycles.
        loadFifos(3, 1'b1, 8);
        applyStimulus(exp_row, 3, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("s3_stall_no_pop", b_rd - pop_base, 0);
        for (int j = 0; j < 8; j++) pushB(bElem(3, j));
        waitDone(exp_row, "s3");

        // Row 5 runs dry after four elements and is refilled two cycles later.
        loadFifos(4, 1'b0, 4);
        applyStimulus(exp_diag, 2, 1'b1);
        for (int n = 0; n < 40 && (b_rd - pop_base) < 4; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        checkOutput("s4_gap_no_pop", b_rd - pop_base, 4);
        for (int j = 4; j < 8; j++) pushA(5, aElem(4, 5, j));
        waitDone(exp_diag, "s4");

        // Stray start during RUN, then a genuine restart after done.
        loadFifos(5, 1'b0, 8);
        applyStimulus(exp_id, 0, 1'b1);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(exp_id, "s5a");
        loadFifos(7, 1'b0, 8);
        applyStimulus(exp_anti, 0, 1'b1);
        waitDone(exp_anti, "s5b");

        // Asynchronous reset after five issues abandons the product.
        loadFifos(6, 1'b0, 8);
        applyStimulus(exp_id, 0, 1'b0);
        for (int n = 0; n < 40 && (b_rd - pop_base) < 5; n++) @(negedge clk);
        checkOutput("s6_pops_before_reset", b_rd - pop_base, 5);
        #1 rst = 1'b1;
        #1;
        checkOutput("s6_async_busy", bus.busy, 0);
        checkOutput("s6_async_rd_en", {bus.fifo_a_rd_en, bus.fifo_b_rd_en}, 0);
        checkOutput("s6_async_result", (bus.result != '0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        flushFifos();
        loadFifos(8, 1'b0, 8);
        applyStimulus(exp_lin, 0, 1'b1);
        waitDone(exp_lin, "s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
